// File: rtl/sync_fifo_flags_if.sv
// Handshake/data bundle between the FIFO and its writer/reader: the master drives requests, the slave (FIFO) returns data and flags.
interface sync_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] d_in;
    logic             rd_en;
    logic [WIDTH-1:0] d_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, d_in, rd_en,
        input  d_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, d_in, rd_en,
        output d_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky errors, flush.
// Latency: 1-cycle registered read (d_out/rd_valid); defining SYNC_FIFO_FWFT_EN gives a fall-through head word.
// Backpressure: a write on full is dropped and sets overflow unless a read pops in the same cycle.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_flags_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_CNT    = CW'(AEMPTY_TH);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             is_full;
    logic             is_empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_q;
    logic             unf_q;

    assign is_full  = (cnt == FULL_CNT);
    assign is_empty = (cnt == '0);
    // A flush cycle ignores both requests; a pop frees the slot a full-cycle write needs.
    assign rd_acc   = bus.rd_en && !is_empty && !bus.clr;
    assign wr_acc   = bus.wr_en && (!is_full || rd_acc) && !bus.clr;

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
            if (bus.wr_en && is_full && !rd_acc) ovf_q <= 1'b1;
            if (bus.rd_en && is_empty)           unf_q <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.d_out    = mem[rd_ptr[AW-1:0]];
    assign bus.rd_valid = !is_empty;
`else
    logic [WIDTH-1:0] dout_q;
    logic             rv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
            rv_q   <= 1'b0;
        end else begin
            rv_q <= rd_acc;
            if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus.d_out    = dout_q;
    assign bus.rd_valid = rv_q;
`endif

    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (cnt >= AF_CNT);
    assign bus.almost_empty = (cnt <= AE_CNT);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    // The wrap bits make the pointer distance an independent witness of the count register.
    ptr_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        CW'(wr_ptr - rd_ptr) == cnt);
endmodule
